// File: rtl/imem_program_loader_if.sv
// Loader-side bundle: session control, byte-stream handshake and the
// core's instruction-memory load interface.
interface imem_program_loader_if #(
   parameter int PC_SIZE = 10
);
   logic               start;
   logic [PC_SIZE:0]   word_count;
   logic [7:0]         byte_in;
   logic               byte_valid;
   logic               byte_ready;
   logic               core_reset;
   logic               reset_IF_memory;
   logic               rw;
   logic [PC_SIZE-1:0] PC_write;
   logic [31:0]        instruction_in;
   logic               busy;
   logic               done;

   modport master (
      output start, word_count, byte_in, byte_valid,
      input  byte_ready, core_reset, reset_IF_memory, rw, PC_write,
             instruction_in, busy, done
   );

   modport slave (
      input  start, word_count, byte_in, byte_valid,
      output byte_ready, core_reset, reset_IF_memory, rw, PC_write,
             instruction_in, busy, done
   );
endinterface

// File: rtl/imem_program_loader.sv
// Byte-stream program loader: assembles little-endian words and writes them
// into the core's instruction memory while holding the core in reset.
module imem_program_loader #(
   parameter int PC_SIZE      = 10,
   parameter int CLEAR_CYCLES = 2
) (
   input logic                  clock,
   input logic                  reset,
   imem_program_loader_if.slave bus
);
   localparam int CW = $clog2(CLEAR_CYCLES + 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RECV, S_WRITE, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [PC_SIZE:0]   wc_q, wc_d;
   logic [PC_SIZE:0]   addr_q, addr_d, addr_inc;
   logic [1:0]         byte_idx_q, byte_idx_d;
   logic [23:0]        word_q, word_d;
   logic [CW-1:0]      clr_cnt_q, clr_cnt_d;
   logic               byte_ready_q, byte_ready_d;
   logic               core_reset_q, core_reset_d;
   logic               rim_q, rim_d;
   logic               rw_q, rw_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [PC_SIZE-1:0] pc_q, pc_d;
   logic [31:0]        instr_q, instr_d;
   logic               accept;

   // byte_ready_q is only ever high in RECV, so it alone qualifies the handshake
   assign accept   = byte_ready_q & bus.byte_valid;
   assign addr_inc = addr_q + (PC_SIZE+1)'(1);

   always_comb begin
      state_d    = state_q;
      wc_d       = wc_q;
      addr_d     = addr_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      clr_cnt_d  = clr_cnt_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               wc_d       = bus.word_count;
               addr_d     = '0;
               byte_idx_d = '0;
               clr_cnt_d  = '0;
               state_d    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            clr_cnt_d = clr_cnt_q + CW'(1);
            if (clr_cnt_q == CW'(CLEAR_CYCLES - 1))
               state_d = (wc_q == '0) ? S_DONE : S_RECV;
         end
         S_RECV: begin
            if (accept) begin
               byte_idx_d = byte_idx_q + 2'd1;
               unique case (byte_idx_q)
                  2'd0: word_d[7:0]   = bus.byte_in;
                  2'd1: word_d[15:8]  = bus.byte_in;
                  2'd2: word_d[23:16] = bus.byte_in;
                  2'd3: begin
                     // top lane goes straight into the output word
                     pc_d    = addr_q[PC_SIZE-1:0];
                     instr_d = {bus.byte_in, word_q};
                     state_d = S_WRITE;
                  end
                  default: ;
               endcase
            end
         end
         S_WRITE: begin
            addr_d  = addr_inc;
            state_d = (addr_inc == wc_q) ? S_DONE : S_RECV;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // outputs are registered, so they follow the state being entered
      byte_ready_d = (state_d == S_RECV);
      busy_d       = (state_d != S_IDLE);
      core_reset_d = busy_d;
      rim_d        = (state_d == S_CLEAR);
      rw_d         = (state_d == S_WRITE);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wc_q         <= '0;
         addr_q       <= '0;
         byte_idx_q   <= '0;
         word_q       <= '0;
         clr_cnt_q    <= '0;
         byte_ready_q <= 1'b0;
         core_reset_q <= 1'b0;
         rim_q        <= 1'b0;
         rw_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pc_q         <= '0;
         instr_q      <= '0;
      end else begin
         state_q      <= state_d;
         wc_q         <= wc_d;
         addr_q       <= addr_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         clr_cnt_q    <= clr_cnt_d;
         byte_ready_q <= byte_ready_d;
         core_reset_q <= core_reset_d;
         rim_q        <= rim_d;
         rw_q         <= rw_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
      end
   end

   assign bus.byte_ready      = byte_ready_q;
   assign bus.core_reset      = core_reset_q;
   assign bus.reset_IF_memory = rim_q;
   assign bus.rw              = rw_q;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;
   assign bus.PC_write        = pc_q;
   assign bus.instruction_in  = instr_q;
endmodule
